// File: rtl/add_round_key_sched.sv
// AddRoundKey stage with a word-serial AES-128/192/256 key schedule.
// Round keys are generated one 32-bit word per cycle into a two-entry
// buffer (current, next); each accepted state is XORed with the current
// round key and registered on the output.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Producers hold data stable while valid && !ready; in_ready may
// depend combinationally on out_ready and key_load, never on in_valid.
module add_round_key_sched #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [32*NK-1:0]  key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_state,
  output logic [3:0]        out_round,
  output logic              out_last,
  output logic              busy
);

  localparam int          NR       = NK + 6;
  localparam int          KEY_BITS = 32 * NK;
  localparam logic [5:0]  TOTAL_W  = 6'(4 * (NR + 1));
  localparam logic [5:0]  NK_W     = 6'(NK);
  localparam logic [2:0]  NK_M1    = 3'(NK - 1);
  localparam logic [3:0]  NR_R     = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // key words (only the first NK used), history window: win[0] = w[i-1]
  logic [31:0]  key_w_q [8];
  logic [31:0]  key_w_d [8];
  logic [31:0]  key_ld  [8];
  logic [31:0]  win_q   [8];
  logic [31:0]  win_d   [8];
  logic [5:0]   i_q, i_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] nxt_q, nxt_d;
  logic         nxt_full_q, nxt_full_d;
  logic [1:0]   wpos_q, wpos_d;
  logic [127:0] cur_q, cur_d;
  logic         cur_full_q, cur_full_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_state_q, out_state_d;
  logic [3:0]   out_round_q, out_round_d;
  logic         out_last_q, out_last_d;

  logic [KEY_BITS-1:0] key_sh;
  logic [31:0]  rot_w, sub_in, sub_out, w_new;
  logic         gen_en, rcon_use, accept, out_fire;

  assign in_ready = cur_full_q && (!out_valid_q || out_ready) && !key_load &&
                    (round_q <= NR_R);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign gen_en   = busy_q && !nxt_full_q && (i_q < TOTAL_W);
  assign rcon_use = (i_q >= NK_W) && (j_q == 3'd0);

  // split the cipher key into words, word 0 taken from the MSBs
  always_comb begin
    key_sh = key_in;
    for (int k = 0; k < 8; k++) begin
      key_ld[k] = key_sh[KEY_BITS-1 -: 32];
      key_sh    = key_sh << 32;
    end
  end

  // next schedule word w[i] from the key or the history window
  always_comb begin
    rot_w   = {win_q[0][23:0], win_q[0][31:24]};
    sub_in  = (j_q == 3'd0) ? rot_w : win_q[0];
    sub_out = sub_word(sub_in);
    w_new   = win_q[NK-1] ^ win_q[0];
    if (i_q < NK_W) begin
      w_new = key_w_q[i_q[2:0]];
    end else if (j_q == 3'd0) begin
      w_new = win_q[NK-1] ^ sub_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && j_q == 3'd4) begin
      w_new = win_q[NK-1] ^ sub_out;
    end
  end

  // next state of the schedule, round-key buffer and output register
  always_comb begin
    key_w_d     = key_w_q;
    win_d       = win_q;
    i_d         = i_q;
    j_d         = j_q;
    rcon_d      = rcon_q;
    nxt_d       = nxt_q;
    nxt_full_d  = nxt_full_q;
    wpos_d      = wpos_q;
    cur_d       = cur_q;
    cur_full_d  = cur_full_q;
    round_d     = round_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    if (key_load) begin
      key_w_d     = key_ld;
      for (int k = 0; k < 8; k++) win_d[k] = 32'h0;
      i_d         = 6'd0;
      j_d         = 3'd0;
      rcon_d      = 8'h01;
      nxt_full_d  = 1'b0;
      wpos_d      = 2'd0;
      cur_full_d  = 1'b0;
      round_d     = 4'd0;
      busy_d      = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      if (gen_en) begin
        win_d[0] = w_new;
        for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
        i_d = i_q + 6'd1;
        j_d = (j_q == NK_M1) ? 3'd0 : j_q + 3'd1;
        if (rcon_use) rcon_d = xtime(rcon_q);
        case (wpos_q)
          2'd0:    nxt_d[127:96] = w_new;
          2'd1:    nxt_d[95:64]  = w_new;
          2'd2:    nxt_d[63:32]  = w_new;
          default: nxt_d[31:0]   = w_new;
        endcase
        wpos_d = wpos_q + 2'd1;
        if (wpos_q == 2'd3) nxt_full_d = 1'b1;
      end
      if (accept) cur_full_d = 1'b0;
      // a completed next key drops into an empty (or just freed) current
      if (nxt_full_d && !cur_full_d) begin
        cur_d      = nxt_d;
        cur_full_d = 1'b1;
        nxt_full_d = 1'b0;
      end
      if (accept) begin
        out_valid_d = 1'b1;
        out_state_d = in_state ^ cur_q;
        out_round_d = round_q;
        out_last_d  = (round_q == NR_R);
        round_d     = round_q + 4'd1;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
      if (out_fire && out_last_q) busy_d = 1'b0;
    end
  end

  // state registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        key_w_q[k] <= 32'h0;
        win_q[k]   <= 32'h0;
      end
      i_q         <= 6'd0;
      j_q         <= 3'd0;
      rcon_q      <= 8'h01;
      nxt_q       <= 128'h0;
      nxt_full_q  <= 1'b0;
      wpos_q      <= 2'd0;
      cur_q       <= 128'h0;
      cur_full_q  <= 1'b0;
      round_q     <= 4'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= 128'h0;
      out_round_q <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      key_w_q     <= key_w_d;
      win_q       <= win_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rcon_q      <= rcon_d;
      nxt_q       <= nxt_d;
      nxt_full_q  <= nxt_full_d;
      wpos_q      <= wpos_d;
      cur_q       <= cur_d;
      cur_full_q  <= cur_full_d;
      round_q     <= round_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add_round_key_sched.sv
// Bench for add_round_key_sched: one AES-128 and one AES-256 instance.
// Expected outputs are queued when a state is handed over; monitors pop and
// compare whenever an output transfer happens.
module tb_add_round_key_sched;

  localparam logic [127:0] K4     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK4_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RK4_2  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
  localparam logic [127:0] RK4_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0    = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] K_ALT  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K8     =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK8_1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK8_2  = 128'ha573c29fa176c498a97fce93a572c09c;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         key_load4, in_valid4, in_ready4, out_valid4, out_ready4;
  logic         out_last4, busy4;
  logic [127:0] key_in4, in_state4, out_state4;
  logic [3:0]   out_round4;
  logic         key_load8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic         out_last8, busy8;
  logic [255:0] key_in8;
  logic [127:0] in_state8, out_state8;
  logic [3:0]   out_round8;

  add_round_key_sched #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_load(key_load4), .key_in(key_in4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_state(in_state4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4),
    .out_round(out_round4), .out_last(out_last4), .busy(busy4)
  );

  add_round_key_sched #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst), .key_load(key_load8), .key_in(key_in8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_state(in_state8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_state(out_state8),
    .out_round(out_round8), .out_last(out_last8), .busy(busy8)
  );

  // ---------------- scoreboard ----------------
  // entry: {check_state, last, round[3:0], state[127:0]}
  logic [133:0] exp4_q[$];
  logic [133:0] exp8_q[$];
  logic [133:0] e4, e8;
  int n_chk  = 0;
  int n_fail = 0;
  int out_cnt8 = 0;

  function automatic logic [133:0] mk(input logic c, input logic l,
                                      input logic [3:0] r, input logic [127:0] s);
    return {c, l, r, s};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL nk4_unexpected_output: got round %0d expected none", out_round4);
      end else begin
        e4 = exp4_q.pop_front();
        chk("nk4_round", 128'(out_round4), 128'(e4[131:128]));
        chk("nk4_last", 128'(out_last4), 128'(e4[132]));
        if (e4[133]) chk("nk4_state", out_state4, e4[127:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid8 && out_ready8) begin
      out_cnt8++;
      if (exp8_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL nk8_unexpected_output: got round %0d expected none", out_round8);
      end else begin
        e8 = exp8_q.pop_front();
        chk("nk8_round", 128'(out_round8), 128'(e8[131:128]));
        chk("nk8_last", 128'(out_last8), 128'(e8[132]));
        if (e8[133]) chk("nk8_state", out_state8, e8[127:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input int which, input logic [127:0] st, input logic [133:0] e);
    int n;
    n = 0;
    if (which == 4) begin in_valid4 = 1'b1; in_state4 = st; end
    else begin in_valid8 = 1'b1; in_state8 = st; end
    @(negedge clk);
    while (!((which == 4) ? in_ready4 : in_ready8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((which == 4) ? in_ready4 : in_ready8) begin
      if (which == 4) exp4_q.push_back(e); else exp8_q.push_back(e);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles expected 1 (nk %0d)", which);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic pulse_key4(input logic [127:0] k);
    key_load4 = 1'b1; key_in4 = k;
    @(posedge clk); #1;
    key_load4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    key_load4 = 0; key_in4 = '0; in_valid4 = 0; in_state4 = '0; out_ready4 = 1;
    key_load8 = 0; key_in8 = '0; in_valid8 = 0; in_state8 = '0; out_ready8 = 1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready4", 128'(in_ready4), 128'd0);
    chk("rst_out_valid4", 128'(out_valid4), 128'd0);
    chk("rst_out_state4", out_state4, 128'd0);
    chk("rst_out_round4", 128'(out_round4), 128'd0);
    chk("rst_out_last4", 128'(out_last4), 128'd0);
    chk("rst_busy4", 128'(busy4), 128'd0);
    chk("rst_in_ready8", 128'(in_ready8), 128'd0);
    chk("rst_out_valid8", 128'(out_valid8), 128'd0);
    chk("rst_busy8", 128'(busy8), 128'd0);

    // first key_load right at reset release, in_ready 4 cycles later
    #9;
    rst = 1'b1;
    key_load4 = 1'b1; key_in4 = K4;
    @(posedge clk); #1;
    key_load4 = 1'b0;
    chk("busy_after_load", 128'(busy4), 128'd1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("in_ready_latency_e%0d", c), 128'(in_ready4), 128'(c == 4));
    end

    // AES-128: round 0 with plaintext, then zero states for rounds 1..10
    send(4, PT, mk(1'b1, 1'b0, 4'd0, CT0));
    for (int r = 1; r <= 10; r++) begin
      if (r == 1)       send(4, '0, mk(1'b1, 1'b0, 4'(r), RK4_1));
      else if (r == 2)  send(4, '0, mk(1'b1, 1'b0, 4'(r), RK4_2));
      else if (r == 10) send(4, '0, mk(1'b1, 1'b1, 4'(r), RK4_10));
      else              send(4, '0, mk(1'b0, 1'b0, 4'(r), '0));
    end
    idle(5);
    chk("done_in_ready", 128'(in_ready4), 128'd0);
    chk("done_busy", 128'(busy4), 128'd0);
    in_valid4 = 1'b1; in_state4 = PT;
    repeat (4) begin
      @(negedge clk);
      chk("done_ignore_in_ready", 128'(in_ready4), 128'd0);
      chk("done_ignore_out_valid", 128'(out_valid4), 128'd0);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;

    // output backpressure: round 0 held 20 cycles, then round 1 with no gap
    out_ready4 = 1'b0;
    pulse_key4(K4);
    send(4, '0, mk(1'b1, 1'b0, 4'd0, K4));
    in_valid4 = 1'b1; in_state4 = '0;
    repeat (20) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid4), 128'd1);
      chk("hold_out_state", out_state4, K4);
      chk("hold_in_ready", 128'(in_ready4), 128'd0);
    end
    @(posedge clk); #1;
    out_ready4 = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready4), 128'd1);
    exp4_q.push_back(mk(1'b1, 1'b0, 4'd1, RK4_1));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    send(4, '0, mk(1'b1, 1'b0, 4'd2, RK4_2));
    @(posedge clk); #1;

    // key_load after round 3 with its output still pending
    out_ready4 = 1'b0;
    send(4, '0, mk(1'b0, 1'b0, 4'd3, '0));
    key_load4 = 1'b1; key_in4 = K_ALT; in_valid4 = 1'b1; in_state4 = PT;
    @(posedge clk); #1;
    key_load4 = 1'b0; in_valid4 = 1'b0;
    chk("reload_out_valid", 128'(out_valid4), 128'd0);
    chk("reload_busy", 128'(busy4), 128'd1);
    void'(exp4_q.pop_back());
    out_ready4 = 1'b1;
    send(4, '0, mk(1'b1, 1'b0, 4'd0, K_ALT));
    idle(2);

    // AES-256: 15 rounds of zero state
    key_load8 = 1'b1; key_in8 = K8;
    @(posedge clk); #1;
    key_load8 = 1'b0;
    for (int r = 0; r <= 14; r++) begin
      if (r == 0)      send(8, '0, mk(1'b1, 1'b0, 4'(r), K8[255:128]));
      else if (r == 1) send(8, '0, mk(1'b1, 1'b0, 4'(r), RK8_1));
      else if (r == 2) send(8, '0, mk(1'b1, 1'b0, 4'(r), RK8_2));
      else             send(8, '0, mk(1'b0, r == 14, 4'(r), '0));
    end
    idle(5);
    chk("nk8_output_count", 128'(out_cnt8), 128'd15);
    chk("nk8_queue_empty", 128'(exp8_q.size()), 128'd0);
    chk("nk8_busy_done", 128'(busy8), 128'd0);
    chk("nk8_in_ready_done", 128'(in_ready8), 128'd0);

    // asynchronous reset in the middle of operation
    out_ready4 = 1'b0;
    send(4, '0, mk(1'b0, 1'b0, 4'd1, '0));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 128'(in_ready4), 128'd0);
    chk("arst_out_valid", 128'(out_valid4), 128'd0);
    chk("arst_out_state", out_state4, 128'd0);
    chk("arst_out_round", 128'(out_round4), 128'd0);
    chk("arst_out_last", 128'(out_last4), 128'd0);
    chk("arst_busy", 128'(busy4), 128'd0);
    exp4_q.delete();
    #3;
    rst = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/add_round_key_sched.md
# add_round_key_sched

Parametrised AddRoundKey stage with an integrated word-serial AES key schedule for AES-128, AES-192 and AES-256.
- Loaded once with a cipher key, it generates round keys on the fly, one 32-bit word per cycle, into a two-deep round-key buffer.
- Each accepted 128-bit state is XORed with the round key for the current round number.
- It sits between the round datapath (SubBytes/ShiftRows/MixColumns) and the round register. Valid/ready handshakes on input and output let the round pipeline stall freely.

## Interface
- NK, default 4: key length in 32-bit words; legal values 4, 6, 8. Derived: NR = NK+6 rounds, KEY_BITS = 32*NK, total words 4*(NR+1).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_load  in  1  one-cycle pulse; samples key_in and restarts the schedule.
- key_in  in  KEY_BITS  cipher key, word 0 in the MSBs.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block accepts in_state this cycle.
- in_state  in  128  state to be keyed, FIPS-197 byte order, MSB = byte 0.
- out_valid  out  1  out_state is valid.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  in_state XOR round key.
- out_round  out  4  round index (0..NR) of the key applied.
- out_last  out  1  high with out_valid when out_round == NR.
- busy  out  1  a key is loaded and rounds 0..NR have not all been consumed.

## Operation
- Reset values: in_ready=0, out_valid=0, out_state=0, out_round=0, out_last=0, busy=0. All buffers are empty, the word counter i=0 and the round counter is 0.
- Key register: on key_load, key_in is stored, i is cleared, both buffers are emptied, the round counter is cleared and busy is set.
- Generator: produces w[i] when i < 4*(NR+1) and the fill buffer has room.
  - i < NK: w[i] = key word i.
  - i mod NK == 0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ Rcon.
  - NK==8 and i mod NK == 4: w[i] = w[i-NK] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-NK] ^ w[i-1].
  - History is held in an 8-word shift window of the last NK words.
  - Rcon is a byte register starting at 0x01 and advanced by xtime each time it is used (0x01, 0x02, …, 0x80, 0x1b, 0x36), then placed in the top byte.
  - The S-box is internal and combinational, one 32-bit SubWord instance.
- Round-key buffer: two entries, current and next.
  - Words fill the next entry in order; after 4 words it is marked full.
  - If current is empty, a full next moves to current in the same cycle.
  - The generator stalls while next is full.
- Input accept: in_ready = current full AND (out_valid==0 OR out_ready).
  - On in_valid && in_ready, the output register loads in_state ^ current, out_round is set to the round counter, and current is freed.
  - The round counter increments.
- Done: after round NR is accepted, in_ready stays 0 and busy falls once out_last is consumed. Further in_valid is ignored until the next key_load.
- key_load while busy: the schedule restarts and the buffers are flushed. A pending out_valid is dropped in the same edge: out_valid=0 after that edge. A simultaneous in_valid is not accepted.
- Output hold: out_state, out_round and out_last are stable while out_valid && !out_ready.

## Timing
- key_load sampled at edge E0. w[0..3] are generated at E1..E4, so round key 0 is current after E4 and in_ready can be 1 in the cycle after E4.
- Generator rate is 1 word/cycle, so round r's key is complete at E(4r+4) when there are no stalls. The next entry lets the generator run up to 8 words ahead.
- Data latency is 1 cycle: an accept at edge T gives out_valid=1 after T.
- Steady throughput is one round per 4 cycles when input is always valid. If input lags, throughput is one round per cycle for up to 2 rounds (both entries full).
- Output backpressure propagates combinationally into in_ready. There is no combinational path from in_valid to out_valid.
- Reset deassertion: the first key_load is honoured on the first rising edge after rst goes high.

## Test plan
- NK=4, key 000102…0f, in_state 00112233445566778899aabbccddeeff at round 0 -> out_state 00102030405060708090a0b0c0d0e0f0, out_round=0; in_ready first high 4 cycles after key_load.
- NK=4, same key, feed zero state for 11 rounds -> round 10 out_state 13111d7fe3944a17f307a78b4d2b30c5, out_last=1, then in_ready stays 0 and busy=0.
- NK=8, key 000102…1f, zero state -> round 1 out_state 101112131415161718191a1b1c1d1e1f; 15 outputs total, out_last on round 14.
- Hold out_ready=0 for 20 cycles after the first accept -> out_state stable, in_ready=0; release -> round 1 is accepted next cycle with no gap, because the buffers are full.
- key_load asserted mid-schedule (after round 3) with out_valid pending -> out_valid=0 next cycle, out_round restarts at 0, round 0 key is the new key.
- Assert rst low mid-operation -> all outputs return to their reset values immediately, without waiting for a clock edge.
